// File: rtl/sdiv_seq.sv
// -----------------------------------------------------------------------------
// sdiv_seq -- sequential signed integer divider (restoring algorithm)
//
// Divides a signed dividend by a signed divisor. Each quotient bit takes one
// clock cycle, so a division finishes DATAWIDTH+1 cycles after start. Division
// by zero skips the iteration and finishes one cycle after start. Results
// truncate toward zero, and the remainder has the same sign as the dividend.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous reset, active low
//   start_i      : latch a_i/b_i and begin a division (ignored while busy_o)
//   a_i          : signed dividend
//   b_i          : signed divisor
//   quot_o       : signed quotient, registered, held until the next result
//   rem_o        : signed remainder, registered, held until the next result
//   busy_o       : high while a division is in progress
//   done_o       : one-cycle pulse when quot_o/rem_o/divbyzero_o are new
//   divbyzero_o  : the last completed division had b == 0
// -----------------------------------------------------------------------------
module sdiv_seq #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  output logic [DATAWIDTH-1:0] quot_o,
  output logic [DATAWIDTH-1:0] rem_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 divbyzero_o
);

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [W-1:0]  ONE   = W'(1);
  localparam logic [CW-1:0] CNT_1 = CW'(1);
  localparam logic [CW-1:0] CNT_W = CW'(DATAWIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q,     a_d;      // raw dividend, returned as remainder on b == 0
  logic [W-1:0]  dvd_q,   dvd_d;    // dividend magnitude; quotient bits shift in at the bottom
  logic [W-1:0]  dvs_q,   dvs_d;    // divisor magnitude
  logic [W-1:0]  prem_q,  prem_d;   // partial remainder (always < divisor magnitude)
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          qneg_q,  qneg_d;
  logic          rneg_q,  rneg_d;
  logic          bzero_q, bzero_d;
  logic [W-1:0]  quot_q,  quot_d;
  logic [W-1:0]  rem_q,   rem_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          dbz_q,   dbz_d;

  // The shifted partial remainder and the trial difference carry one extra
  // bit: a divisor magnitude of 2^(W-1) would otherwise overflow, and the top
  // bit of the difference is the borrow that decides the quotient bit.
  logic [W:0] rem_shift;
  logic [W:0] diff;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    bzero_d   = bzero_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    rem_shift = {prem_q, dvd_q[W-1]};
    diff      = rem_shift - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          dvd_d   = a_i[W-1] ? (~a_i + ONE) : a_i;
          dvs_d   = b_i[W-1] ? (~b_i + ONE) : b_i;
          prem_d  = '0;
          cnt_d   = CNT_W;
          qneg_d  = a_i[W-1] ^ b_i[W-1];
          rneg_d  = a_i[W-1];
          bzero_d = (b_i == '0);
          busy_d  = 1'b1;
          state_d = (b_i == '0) ? FIX : CALC;
        end
      end

      CALC: begin
        if (!diff[W]) begin
          prem_d = diff[W-1:0];
          dvd_d  = {dvd_q[W-2:0], 1'b1};
        end else begin
          prem_d = rem_shift[W-1:0];
          dvd_d  = {dvd_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_1;
        if (cnt_q == CNT_1) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (bzero_q) begin
          quot_d = '1;
          rem_d  = a_q;
          dbz_d  = 1'b1;
        end else begin
          // most-negative / -1 wraps back to most-negative here, which is
          // the exact W-bit result; no error is flagged for it.
          quot_d = qneg_q ? (~dvd_q + ONE) : dvd_q;
          rem_d  = rneg_q ? (~prem_q + ONE) : prem_q;
          dbz_d  = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quot_o      = quot_q;
  assign rem_o       = rem_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign divbyzero_o = dbz_q;

endmodule

// File: doc/sdiv_seq.md
SDIV_SEQ -- requirements
Module: sdiv_seq

Interface
REQ-001 Parameter DATAWIDTH, default 64, SHALL set the operand width in bits, and the block SHALL support any DATAWIDTH >= 2.
REQ-002 Clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-003 Rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 start  input  1  SHALL be the request to latch operands and begin a division.
REQ-005 a  input  DATAWIDTH  SHALL be the signed (two's complement) dividend.
REQ-006 b  input  DATAWIDTH  SHALL be the signed (two's complement) divisor.
REQ-007 quot  output  DATAWIDTH  SHALL be the signed quotient, registered.
REQ-008 rem  output  DATAWIDTH  SHALL be the signed remainder, registered.
REQ-009 busy  output  1  SHALL be high while a division is in progress.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking that quot/rem are newly valid.
REQ-011 divbyzero  output  1  SHALL flag that the last completed division had b == 0, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, FIX.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL latch a and b, convert both to magnitudes, clear the partial remainder, set the iteration counter to DATAWIDTH, assert busy, and go to CALC.
REQ-014 If the latched b == 0, the block SHALL go to FIX instead of CALC, skipping iteration.
REQ-015 CALC SHALL perform one restoring-division step per cycle: shift {partial remainder, dividend magnitude} left by 1, trial-subtract the divisor magnitude, keep the difference and shift in quotient bit 1 if it is non-negative, and otherwise restore and shift in 0.
REQ-016 CALC SHALL decrement the counter each cycle and go to FIX after exactly DATAWIDTH steps.
REQ-017 The partial remainder and trial subtraction SHALL be DATAWIDTH+1 bits wide so that a magnitude of 2^(DATAWIDTH-1) cannot overflow.
REQ-018 FIX SHALL apply sign correction (quotient negated if sign(a) XOR sign(b); remainder negated if a < 0), register quot, rem and divbyzero, pulse done for one cycle, clear busy, and return to IDLE.
REQ-019 Results SHALL truncate toward zero, with rem carrying the sign of a and a == quot*b + rem holding exactly in DATAWIDTH bits.
REQ-020 Latency SHALL be DATAWIDTH+1 cycles from the start-sampling edge to the done edge for b != 0, and 1 cycle for b == 0.
REQ-021 On division by zero, quot SHALL be all ones, rem SHALL equal a, and divbyzero SHALL be 1.
REQ-022 For a = most-negative and b = -1, quot SHALL be the most-negative value, rem SHALL be 0, and divbyzero SHALL be 0, with no error flag.
REQ-023 start while busy=1 SHALL be ignored, and the operands of the in-flight operation SHALL be unaffected.
REQ-024 start asserted in IDLE during the cycle in which done is high SHALL begin a new division, which makes back-to-back operation possible.
REQ-025 quot, rem and divbyzero SHALL hold their values from done until the next FIX; a and b changing after the start edge SHALL have no effect.

Reset
REQ-026 Rst low SHALL immediately force the state to IDLE and set quot=0, rem=0, busy=0, done=0, divbyzero=0, and counter=0, regardless of the clock.
REQ-027 Rst asserted mid-CALC SHALL abort the division with no done pulse, and after release the block SHALL accept a new start normally.

Verification (DATAWIDTH=8)
REQ-028 a=100, b=7, start pulse -> done exactly 9 cycles later; quot=14, rem=2, divbyzero=0; busy high for 9 cycles.
REQ-029 a=-100, b=7 -> quot=-14 (0xF2), rem=-2 (0xFE); a=7, b=-100 -> quot=0, rem=7.
REQ-030 a=-128, b=-1 -> quot=-128 (0x80), rem=0; a=-128, b=3 -> quot=-42, rem=-2.
REQ-031 a=5, b=0 -> done 1 cycle after start; quot=0xFF, rem=5, divbyzero=1; the next division 9/3 clears divbyzero and gives quot=3, rem=0.
REQ-032 Start 100/7, then re-assert start with 50/5 at cycle 3 -> the second start is ignored and the result is 14 r 2; then start asserted during done -> the next result is 10 r 0 after 9 cycles.
REQ-033 Start 100/7, assert Rst at cycle 4 -> all outputs 0 immediately with no done; after release, 20/6 -> quot=3, rem=2.
